// File: rtl/tx_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared receiver.
// The slave modport is the arbiter's view; master is the environment's view.
interface tx_arbiter_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic [M-1:0]   req_valid_i;
    logic [M*N-1:0] req_data_i;
    logic [M-1:0]   req_ready_o;
    logic           valid_o;
    logic [N-1:0]   data_o;
    logic           rx_ready_i;
    logic           rx_busy_i;
    logic [M-1:0]   grant_o;
    logic           err_o;

    modport slave (
        input  req_valid_i, req_data_i, rx_ready_i, rx_busy_i,
        output req_ready_o, valid_o, data_o, grant_o, err_o
    );

    modport master (
        output req_valid_i, req_data_i, rx_ready_i, rx_busy_i,
        input  req_ready_o, valid_o, data_o, grant_o, err_o
    );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter forwarding one word at a time from M requesters to a
// single receiver, dropping a word (with an err_o pulse) if it waits too long.
module tx_arbiter #(
    parameter int N       = 4,
    parameter int M       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    tx_arbiter_if.slave  bus
);
    localparam int PW = $clog2(M);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [CW-1:0]   r_cnt;
    logic            r_valid;
    logic [N-1:0]    r_data;
    logic [M-1:0]    r_grant;
    logic            r_err;

    state_t          w_state_nxt;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   w_owner_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_valid_nxt;
    logic [N-1:0]    w_data_nxt;
    logic [M-1:0]    w_grant_nxt;
    logic            w_err_nxt;
    logic [M-1:0]    w_req_ready;
    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic [PW-1:0]   w_owner_inc;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < M; k++) begin
            idx = (int'(r_ptr) + k) % M;
            if (!w_found && bus.req_valid_i[idx]) begin
                w_found  = 1'b1;
                w_winner = PW'(idx);
            end
        end
    end

    assign w_owner_inc = (r_owner == PW'(M - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; an unassigned path would infer a latch.
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_grant_nxt = r_grant;
        w_err_nxt   = 1'b0;
        w_req_ready = '0;

        case (r_state)
            ST_IDLE: begin
                // The winner is always valid, so offering ready is acceptance.
                if (!rst && !bus.rx_busy_i && w_found) begin
                    w_req_ready[w_winner] = 1'b1;
                    w_state_nxt           = ST_XFER;
                    w_owner_nxt           = w_winner;
                    w_cnt_nxt             = '0;
                    w_valid_nxt           = 1'b1;
                    w_data_nxt            = bus.req_data_i[int'(w_winner)*N +: N];
                    w_grant_nxt           = '0;
                    w_grant_nxt[w_winner] = 1'b1;
                end
            end
            ST_XFER: begin
                // Completion outranks the timeout when both land on one edge.
                if (r_valid && bus.rx_ready_i) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_owner_inc;
                end else if (!bus.rx_busy_i) begin
                    if (r_cnt == CW'(TIMEOUT - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_grant_nxt = '0;
                        w_ptr_nxt   = w_owner_inc;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_grant <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_grant <= w_grant_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.valid_o     = r_valid;
    assign bus.data_o      = r_data;
    assign bus.grant_o     = r_grant;
    assign bus.err_o       = r_err;
endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with N=4, M=4, TIMEOUT=16; expected values
// are written out by hand for each scenario.
module tb_tx_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tx_arbiter_if #(.N(4), .M(4)) bus ();

    tx_arbiter #(.N(4), .M(4), .TIMEOUT(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid_i = '0;
        bus.rx_ready_i  = 1'b0;
        bus.rx_busy_i   = 1'b0;
        bus.req_data_i  = 16'h4321;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.req_valid_i = 4'b1111;
        tick();
        tick();
        checks++;
        if ({bus.valid_o, bus.grant_o, bus.err_o, bus.data_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b g=%b e=%b d=%h expected all 0",
                     bus.valid_o, bus.grant_o, bus.err_o, bus.data_o);
        end
        checks++;
        if (bus.req_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0000", bus.req_ready_o);
        end
        rst = 1'b0;
        bus.req_valid_i = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bus.req_data_i  = 16'h00A0;
        bus.req_valid_i = 4'b0010;
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL single_ready: got %b expected 0010", bus.req_ready_o);
        end
        tick();
        checks++;
        if ({bus.valid_o, bus.grant_o, bus.data_o} !== {1'b1, 4'b0010, 4'hA}) begin
            errors++;
            $display("FAIL single_grant: got v=%b g=%b d=%h expected v=1 g=0010 d=a",
                     bus.valid_o, bus.grant_o, bus.data_o);
        end
        checks++;
        if (bus.req_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL single_ready_xfer: got %b expected 0000", bus.req_ready_o);
        end
        bus.req_valid_i = 4'b0000;
        bus.req_data_i  = 16'h0050;
        bus.rx_ready_i  = 1'b1;
        #1;
        checks++;
        if (bus.data_o !== 4'hA) begin
            errors++;
            $display("FAIL single_hold: got d=%h expected a", bus.data_o);
        end
        tick();
        checks++;
        if ({bus.valid_o, bus.grant_o, bus.err_o} !== 6'b0) begin
            errors++;
            $display("FAIL single_done: got v=%b g=%b e=%b expected all 0",
                     bus.valid_o, bus.grant_o, bus.err_o);
        end
        // Pointer now 2: requester 2 beats requester 0.
        bus.rx_ready_i  = 1'b0;
        bus.req_data_i  = 16'h4321;
        bus.req_valid_i = 4'b0101;
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL single_ptr: got %b expected 0100", bus.req_ready_o);
        end
        tick();
        checks++;
        if ({bus.grant_o, bus.data_o} !== {4'b0100, 4'h3}) begin
            errors++;
            $display("FAIL single_ptr_grant: got g=%b d=%h expected g=0100 d=3",
                     bus.grant_o, bus.data_o);
        end
        bus.req_valid_i = '0;
        bus.rx_ready_i  = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [3:0] exp_d;
        do_reset();
        bus.req_valid_i = 4'b1111;
        bus.rx_ready_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            exp_d = 4'((i % 4) + 1);
            tick();
            checks++;
            if ({bus.valid_o, bus.grant_o, bus.data_o} !== {1'b1, exp_g, exp_d}) begin
                errors++;
                $display("FAIL rr_grant%0d: got v=%b g=%b d=%h expected v=1 g=%b d=%h",
                         i, bus.valid_o, bus.grant_o, bus.data_o, exp_g, exp_d);
            end
            tick();
            checks++;
            if ({bus.valid_o, bus.grant_o} !== 5'b0) begin
                errors++;
                $display("FAIL rr_idle%0d: got v=%b g=%b expected v=0 g=0000",
                         i, bus.valid_o, bus.grant_o);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_busy();
        do_reset();
        bus.rx_busy_i   = 1'b1;
        bus.req_valid_i = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({bus.req_ready_o, bus.valid_o} !== 5'b0) begin
                errors++;
                $display("FAIL busy_block%0d: got r=%b v=%b expected r=0000 v=0",
                         i, bus.req_ready_o, bus.valid_o);
            end
            tick();
        end
        bus.rx_busy_i = 1'b0;
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL busy_release_ready: got %b expected 0001", bus.req_ready_o);
        end
        tick();
        checks++;
        if ({bus.valid_o, bus.grant_o} !== {1'b1, 4'b0001}) begin
            errors++;
            $display("FAIL busy_release_grant: got v=%b g=%b expected v=1 g=0001",
                     bus.valid_o, bus.grant_o);
        end
        bus.req_valid_i = '0;
        bus.rx_ready_i  = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req_valid_i = 4'b0011;
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bus.valid_o, bus.grant_o, bus.err_o} !== {1'b1, 4'b0001, 1'b0}) begin
                errors++;
                $display("FAIL timeout_wait%0d: got v=%b g=%b e=%b expected v=1 g=0001 e=0",
                         i, bus.valid_o, bus.grant_o, bus.err_o);
            end
            tick();
        end
        checks++;
        if ({bus.valid_o, bus.grant_o, bus.err_o} !== {1'b0, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL timeout_drop: got v=%b g=%b e=%b expected v=0 g=0000 e=1",
                     bus.valid_o, bus.grant_o, bus.err_o);
        end
        checks++;
        if (bus.req_ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_next_ready: got %b expected 0010", bus.req_ready_o);
        end
        tick();
        checks++;
        if ({bus.valid_o, bus.grant_o, bus.err_o} !== {1'b1, 4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL timeout_next_grant: got v=%b g=%b e=%b expected v=1 g=0010 e=0",
                     bus.valid_o, bus.grant_o, bus.err_o);
        end
        bus.req_valid_i = '0;
        bus.rx_ready_i  = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_ready_at_limit();
        do_reset();
        bus.req_valid_i = 4'b0001;
        tick();
        bus.req_valid_i = '0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bus.valid_o, bus.err_o} !== 2'b10) begin
                errors++;
                $display("FAIL limit_wait%0d: got v=%b e=%b expected v=1 e=0",
                         i, bus.valid_o, bus.err_o);
            end
            if (i < 15) tick();
        end
        bus.rx_ready_i = 1'b1;
        tick();
        checks++;
        if ({bus.valid_o, bus.grant_o, bus.err_o} !== 6'b0) begin
            errors++;
            $display("FAIL limit_complete: got v=%b g=%b e=%b expected all 0",
                     bus.valid_o, bus.grant_o, bus.err_o);
        end
        bus.rx_ready_i = 1'b0;
        tick();
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL limit_no_err: got e=%b expected 0", bus.err_o);
        end
    endtask

    task automatic test_busy_freeze();
        do_reset();
        bus.req_valid_i = 4'b0001;
        tick();
        bus.req_valid_i = '0;
        for (int i = 0; i < 19; i++) begin
            bus.rx_busy_i = (i < 3);
            checks++;
            if ({bus.valid_o, bus.err_o} !== 2'b10) begin
                errors++;
                $display("FAIL freeze_wait%0d: got v=%b e=%b expected v=1 e=0",
                         i, bus.valid_o, bus.err_o);
            end
            tick();
        end
        bus.rx_busy_i = 1'b0;
        checks++;
        if ({bus.valid_o, bus.grant_o, bus.err_o} !== {1'b0, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL freeze_drop: got v=%b g=%b e=%b expected v=0 g=0000 e=1",
                     bus.valid_o, bus.grant_o, bus.err_o);
        end
        tick();
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL freeze_err_pulse: got e=%b expected 0", bus.err_o);
        end
    endtask

    task automatic test_reset_xfer();
        do_reset();
        bus.req_valid_i = 4'b0010;
        tick();
        bus.req_valid_i = '0;
        bus.rx_ready_i  = 1'b1;
        tick();
        bus.rx_ready_i  = 1'b0;
        bus.req_valid_i = 4'b0100;
        tick();
        checks++;
        if ({bus.valid_o, bus.grant_o} !== {1'b1, 4'b0100}) begin
            errors++;
            $display("FAIL rstx_grant: got v=%b g=%b expected v=1 g=0100",
                     bus.valid_o, bus.grant_o);
        end
        rst             = 1'b1;
        bus.req_valid_i = 4'b1111;
        tick();
        checks++;
        if ({bus.valid_o, bus.grant_o, bus.err_o, bus.data_o, bus.req_ready_o} !== 14'b0) begin
            errors++;
            $display("FAIL rstx_clear: got v=%b g=%b e=%b d=%h r=%b expected all 0",
                     bus.valid_o, bus.grant_o, bus.err_o, bus.data_o, bus.req_ready_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL rstx_ptr0: got %b expected 0001", bus.req_ready_o);
        end
        tick();
        checks++;
        if ({bus.valid_o, bus.grant_o, bus.err_o} !== {1'b1, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL rstx_regrant: got v=%b g=%b e=%b expected v=1 g=0001 e=0",
                     bus.valid_o, bus.grant_o, bus.err_o);
        end
        idle_inputs();
        bus.rx_ready_i = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_busy();
        test_timeout();
        test_ready_at_limit();
        test_busy_freeze();
        test_reset_xfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
